// File: rtl/adc_frame_buffer.sv
// Frame-aligned FIFO after the ADC: writes frames, releases them only once committed (FWFT output, 1 cycle from last sample to tvalid).
// Input is never stalled; on full the partial frame is rolled back and the rest of that frame discarded, output honours tready.
module adc_frame_buffer #(
   parameter int WIDTH     = 32,
   parameter int FRAME_LEN = 64,
   parameter int DEPTH     = 128,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_axis_tvalid,
   input  logic [WIDTH-1:0] s_axis_tdata,
   output logic             s_axis_tready,
   output logic             m_axis_tvalid,
   output logic [WIDTH-1:0] m_axis_tdata,
   output logic             m_axis_tlast,
   input  logic             m_axis_tready,
   input  logic             clr_ovf,
   output logic             ovf,
   output logic [CNT_W-1:0] drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(FRAME_LEN);
   localparam logic [0:0]    ST_FILL    = 1'b0;
   localparam logic [0:0]    ST_DISCARD = 1'b1;
   localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   PTR_ONE    = (AW+1)'(1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(FRAME_LEN - 1);
   localparam logic [IW-1:0] IDX_ONE    = IW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW:0]      wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
   logic [IW-1:0]    in_idx_q, in_idx_d, out_idx_q, out_idx_d;
   logic [0:0]       state_q, state_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic [AW:0] occ;
   logic        full, beat, in_last, out_last, rd_fire, mem_we, ovf_ev;

   assign s_axis_tready = rst;
   assign beat          = s_axis_tvalid & s_axis_tready;
   assign occ           = wr_q - rd_q;
   assign full          = (occ == DEPTH_C);
   assign in_last       = (in_idx_q == IDX_LAST);
   assign out_last      = (out_idx_q == IDX_LAST);

   // Only committed data is visible, so a rollback never retracts a presented beat.
   assign m_axis_tvalid = (rd_q != commit_q);
   assign m_axis_tdata  = mem[rd_q[AW-1:0]];
   assign m_axis_tlast  = m_axis_tvalid & out_last;
   assign rd_fire       = m_axis_tvalid & m_axis_tready;

   assign ovf      = ovf_q;
   assign drop_cnt = drop_q;

   always_comb begin
      wr_d      = wr_q;
      commit_d  = commit_q;
      rd_d      = rd_q;
      in_idx_d  = in_idx_q;
      out_idx_d = out_idx_q;
      state_d   = state_q;
      ovf_d     = ovf_q;
      drop_d    = drop_q;
      mem_we    = 1'b0;
      ovf_ev    = 1'b0;

      if (rd_fire) begin
         rd_d      = rd_q + PTR_ONE;
         out_idx_d = out_last ? '0 : out_idx_q + IDX_ONE;
      end

      if (beat) begin
         in_idx_d = in_last ? '0 : in_idx_q + IDX_ONE;
         if (state_q == ST_FILL) begin
            if (!full) begin
               mem_we = 1'b1;
               wr_d   = wr_q + PTR_ONE;
               if (in_last) commit_d = wr_q + PTR_ONE;
            end else begin
               wr_d   = commit_q;
               ovf_ev = 1'b1;
               if (drop_q != '1) drop_d = drop_q + CNT_ONE;
               if (!in_last) state_d = ST_DISCARD;
            end
         end else if (in_last) begin
            state_d = ST_FILL;
         end
      end

      // A fresh overflow beats a simultaneous clear.
      if (ovf_ev)       ovf_d = 1'b1;
      else if (clr_ovf) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q      <= '0;
         commit_q  <= '0;
         rd_q      <= '0;
         in_idx_q  <= '0;
         out_idx_q <= '0;
         state_q   <= ST_FILL;
         ovf_q     <= 1'b0;
         drop_q    <= '0;
      end else begin
         wr_q      <= wr_d;
         commit_q  <= commit_d;
         rd_q      <= rd_d;
         in_idx_q  <= in_idx_d;
         out_idx_q <= out_idx_d;
         state_q   <= state_d;
         ovf_q     <= ovf_d;
         drop_q    <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_q[AW-1:0]] <= s_axis_tdata;
   end
endmodule

// File: tb/tb_adc_frame_buffer.sv
// Bench for adc_frame_buffer: vector table, directed corner sequences, then random traffic against a queue model.
module tb_adc_frame_buffer;
   localparam int WIDTH = 32;
   localparam int FL    = 8;
   localparam int DEPTH = 16;
   localparam int CNT_W = 2;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             s_vld = 1'b0;
   logic [WIDTH-1:0] s_dat = '0;
   logic             s_rdy;
   logic             m_vld;
   logic [WIDTH-1:0] m_dat;
   logic             m_last;
   logic             m_rdy = 1'b0;
   logic             clr = 1'b0;
   logic             ovf;
   logic [CNT_W-1:0] drop;

   adc_frame_buffer #(.WIDTH(WIDTH), .FRAME_LEN(FL), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(s_vld), .s_axis_tdata(s_dat), .s_axis_tready(s_rdy),
      .m_axis_tvalid(m_vld), .m_axis_tdata(m_dat), .m_axis_tlast(m_last), .m_axis_tready(m_rdy),
      .clr_ovf(clr), .ovf(ovf), .drop_cnt(drop)
   );

   initial forever #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: committed frames queue, pending partial frame, sample/beat counters.
   bit               rnd = 0;
   logic [WIDTH-1:0] q_out[$];
   logic [WIDTH-1:0] q_pend[$];
   int               in_cnt, out_cnt, m_drop;
   bit               m_disc, m_ovf;

   task automatic model_reset();
      q_out.delete(); q_pend.delete();
      in_cnt = 0; out_cnt = 0; m_drop = 0; m_disc = 0; m_ovf = 0;
   endtask

   task automatic model_step();
      int occ;
      bit ev;
      occ = q_out.size() + q_pend.size();
      ev  = 0;
      if (m_rdy && q_out.size() > 0) begin
         void'(q_out.pop_front());
         out_cnt = (out_cnt + 1) % FL;
      end
      if (s_vld) begin
         if (!m_disc) begin
            if (occ < DEPTH) begin
               q_pend.push_back(s_dat);
               if (in_cnt == FL-1) begin
                  foreach (q_pend[k]) q_out.push_back(q_pend[k]);
                  q_pend.delete();
               end
            end else begin
               q_pend.delete();
               ev = 1;
               if (m_drop < SAT) m_drop++;
               m_disc = (in_cnt != FL-1);
            end
         end else if (in_cnt == FL-1) begin
            m_disc = 0;
         end
         in_cnt = (in_cnt + 1) % FL;
      end
      if (ev) m_ovf = 1;
      else if (clr) m_ovf = 0;
   endtask

   task automatic set_in(input logic v, input logic [31:0] d, input logic r, input logic c);
      @(negedge clk);
      s_vld = v; s_dat = d; m_rdy = r; clr = c;
      #1;
      if (rnd) begin
         chk("rnd_tvalid", 32'(m_vld), 32'(q_out.size() > 0));
         if (q_out.size() > 0) begin
            chk("rnd_tdata", m_dat, q_out[0]);
            chk("rnd_tlast", 32'(m_last), 32'(out_cnt == FL-1));
         end
         chk("rnd_ovf", 32'(ovf), 32'(m_ovf));
         chk("rnd_drop", 32'(drop), 32'(m_drop));
      end
   endtask

   task automatic clk_edge();
      @(posedge clk);
      if (rnd) model_step();
      #1;
   endtask

   task automatic feed(input int first, input int n, input logic r);
      for (int i = 0; i < n; i++) begin
         set_in(1'b1, 32'(first + i), r, 1'b0);
         clk_edge();
      end
   endtask

   task automatic drain_check(input int first, input int n, input int idx0);
      for (int k = 0; k < n; k++) begin
         set_in(1'b0, 32'd0, 1'b1, 1'b0);
         chk("drain_tvalid", 32'(m_vld), 32'd1);
         chk("drain_tdata", m_dat, 32'(first + k));
         chk("drain_tlast", 32'(m_last), 32'((idx0 + k) % FL == FL-1));
         clk_edge();
      end
      set_in(1'b0, 32'd0, 1'b0, 1'b0);
      chk("drain_empty", 32'(m_vld), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; s_vld = 1'b0; m_rdy = 1'b0; clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        r;
      logic        e_vld;
      logic [31:0] e_dat;
      logic        e_last;
   } vec_t;
   vec_t tbl[18];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Pass-through: 8 samples in, then 8 beats out with one stall cycle.
      for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 32'(i), 1'b1, 1'b0, 32'd0, 1'b0};
      for (int k = 0; k < 9; k++)
         tbl[8+k] = '{1'b0, 32'd0, (k != 3), 1'b1, 32'((k <= 3) ? k : k - 1), (k == 8)};
      tbl[17] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0};

      model_reset();
      #2;
      chk("reset_tvalid", 32'(m_vld), 32'd0);
      chk("reset_tlast", 32'(m_last), 32'd0);
      chk("reset_tready", 32'(s_rdy), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);
      chk("reset_drop", 32'(drop), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("run_tready", 32'(s_rdy), 32'd1);

      for (int i = 0; i < 18; i++) begin
         set_in(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
         chk("tbl_tvalid", 32'(m_vld), 32'(tbl[i].e_vld));
         if (tbl[i].e_vld) begin
            chk("tbl_tdata", m_dat, tbl[i].e_dat);
            chk("tbl_tlast", 32'(m_last), 32'(tbl[i].e_last));
         end
         chk("tbl_ovf", 32'(ovf), 32'd0);
         clk_edge();
      end

      // Whole-frame overflow.
      do_reset();
      feed(0, 24, 1'b0);
      chk("wf_ovf", 32'(ovf), 32'd1);
      chk("wf_drop", 32'(drop), 32'd1);
      drain_check(0, 16, 0);

      // Partial rollback.
      do_reset();
      feed(0, 8, 1'b0);
      for (int k = 0; k < 2; k++) begin
         set_in(1'b0, 32'd0, 1'b1, 1'b0);
         chk("pr_read", m_dat, 32'(k));
         clk_edge();
      end
      feed(8, 16, 1'b0);
      chk("pr_ovf", 32'(ovf), 32'd1);
      chk("pr_drop", 32'(drop), 32'd1);
      drain_check(2, 14, 2);
      feed(24, 8, 1'b0);
      drain_check(24, 8, 0);

      // Clear racing a new overflow, then a lone clear.
      feed(32'h100, 16, 1'b0);
      chk("cr_pre_drop", 32'(drop), 32'd1);
      set_in(1'b1, 32'h200, 1'b0, 1'b1);
      clk_edge();
      chk("cr_ovf_set_wins", 32'(ovf), 32'd1);
      chk("cr_drop", 32'(drop), 32'd2);
      feed(32'h201, 7, 1'b0);
      chk("cr_drop_per_frame", 32'(drop), 32'd2);
      set_in(1'b0, 32'd0, 1'b0, 1'b1);
      clk_edge();
      chk("cr_ovf_cleared", 32'(ovf), 32'd0);

      // Saturation: three more dropped frames (five total).
      for (int f = 0; f < 3; f++) begin
         feed(32'h300 + f * FL, FL, 1'b0);
         chk("sat_drop", 32'(drop), 32'(SAT));
         chk("sat_ovf", 32'(ovf), 32'd1);
      end

      // Reset mid-frame on both sides.
      for (int k = 0; k < 3; k++) begin
         set_in(1'b0, 32'd0, 1'b1, 1'b0);
         clk_edge();
      end
      feed(32'h400, 3, 1'b0);
      set_in(1'b0, 32'd0, 1'b0, 1'b0);
      chk("rs_pre_tvalid", 32'(m_vld), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rs_tvalid", 32'(m_vld), 32'd0);
      chk("rs_tlast", 32'(m_last), 32'd0);
      chk("rs_tready", 32'(s_rdy), 32'd0);
      chk("rs_ovf", 32'(ovf), 32'd0);
      chk("rs_drop", 32'(drop), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      feed(100, 7, 1'b0);
      chk("rs_no_early", 32'(m_vld), 32'd0);
      feed(107, 1, 1'b0);
      drain_check(100, 8, 0);

      // Randomised traffic against the model.
      do_reset();
      rnd = 1;
      for (int seg = 0; seg < 15; seg++) begin
         int pr;
         pr = $urandom_range(0, 100);
         for (int c = 0; c < 200; c++) begin
            set_in($urandom_range(0, 99) < 85, $urandom, $urandom_range(0, 99) < pr,
                   $urandom_range(0, 99) < 4);
            clk_edge();
         end
      end
      rnd = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
